// File: rtl/bp_engine_result_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bp_engine_result_arbiter_pkg
// Shared definitions for the engine result arbiter: the frame header tag,
// the frame length helper and the arbiter FSM state type.
// -----------------------------------------------------------------------------
package bp_engine_result_arbiter_pkg;

   // Upper nibble of every frame header byte; lower nibble carries the engine index.
   localparam logic [3:0] FRAME_HDR_TAG = 4'hA;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      SEND  = 2'd2
   } arb_state_t;

   // One header byte followed by the record bytes.
   function automatic int frame_len(input int record_bytes);
      return record_bytes + 1;
   endfunction

endpackage

// File: rtl/bp_engine_result_arbiter_rr_arbiter_prio.sv
// -----------------------------------------------------------------------------
// rr_arbiter_prio
// Combinational round-robin priority pick: returns the first asserted request
// at or after ptr, searching cyclically.
// Ports:
//   req   - request vector, one bit per engine
//   ptr   - engine index with highest priority this cycle
//   idx   - selected engine index (0 when nothing is requesting)
//   found - at least one request is asserted
// -----------------------------------------------------------------------------
module rr_arbiter_prio #(
   parameter int N     = 8,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   logic [IDX_W:0] cand;

   // NOTE: every signal driven here gets a default before any branch; a path
   // that leaves one unassigned would infer a latch.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = 0; k < N; k++) begin
         // ptr + k folded back into 0..N-1 (N need not be a power of two)
         cand = {1'b0, ptr} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
         if (!found && req[cand[IDX_W-1:0]]) begin
            found = 1'b1;
            idx   = cand[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/bp_engine_result_arbiter.sv
// -----------------------------------------------------------------------------
// bp_engine_result_arbiter
// Shares one bulk-IN byte stream between N_ENGINE correlation engines. Engines
// are granted round-robin; each granted record is sent as a frame
// {A, engine_idx} followed by the record bytes LSB first, and o_last marks
// USB packet boundaries (full MAX_PKT packets, or a short packet when the
// stream is about to go quiet).
// Ports:
//   i_clk, i_rst_n  - clock, asynchronous active-low reset
//   i_cg            - clock-gate enable; 0 freezes all state and masks o_ack
//   i_enable        - arbitration enable; 0 lets the current frame finish
//   i_req, i_record - per-engine level requests and packed result records
//   o_ack           - one-cycle pulse to the engine whose record was captured
//   o_data, o_valid, i_ready, o_last - byte stream with valid/ready handshake
//   o_busy          - FSM not in IDLE
// -----------------------------------------------------------------------------
module bp_engine_result_arbiter
   import bp_engine_result_arbiter_pkg::*;
#(
   parameter int N_ENGINE     = 8,
   parameter int RECORD_BYTES = 4,
   parameter int MAX_PKT      = 16
) (
   input  logic                               i_clk,
   input  logic                               i_rst_n,
   input  logic                               i_cg,
   input  logic                               i_enable,
   input  logic [N_ENGINE-1:0]                i_req,
   input  logic [N_ENGINE*RECORD_BYTES*8-1:0] i_record,
   output logic [N_ENGINE-1:0]                o_ack,
   output logic [7:0]                         o_data,
   output logic                               o_valid,
   input  logic                               i_ready,
   output logic                               o_last,
   output logic                               o_busy
);

   localparam int REC_W     = RECORD_BYTES * 8;
   localparam int FRAME_LEN = frame_len(RECORD_BYTES);
   localparam int IDX_W     = $clog2(N_ENGINE);
   localparam int BI_W      = $clog2(FRAME_LEN);
   localparam int PC_W      = $clog2(MAX_PKT);

   localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(FRAME_LEN - 1);
   localparam logic [PC_W-1:0] PKT_END   = PC_W'(MAX_PKT - 1);

   arb_state_t        state, state_nxt;
   logic [IDX_W-1:0]  rr_ptr;
   logic [BI_W-1:0]   byte_idx;
   logic [PC_W-1:0]   pkt_cnt;
   logic [REC_W-1:0]  hold_rec;
   logic [IDX_W-1:0]  hold_idx;

   logic [IDX_W-1:0]  pick_idx;
   logic              pick_found;
   logic [REC_W-1:0]  sel_rec;
   logic [7:0]        frame_byte;
   logic              more_work;
   logic              last_byte;
   logic              xfer;

   rr_arbiter_prio #(
      .N     (N_ENGINE),
      .IDX_W (IDX_W)
   ) u_prio (
      .req   (i_req),
      .ptr   (rr_ptr),
      .idx   (pick_idx),
      .found (pick_found)
   );

   // Record of the picked engine; constant-index mux keeps the select simple.
   always_comb begin
      sel_rec = '0;
      for (int e = 0; e < N_ENGINE; e++) begin
         if (pick_idx == IDX_W'(e)) sel_rec = i_record[e*REC_W +: REC_W];
      end
   end

   // Byte 0 is the header, bytes 1..RECORD_BYTES come from the held record.
   always_comb begin
      frame_byte = {FRAME_HDR_TAG, 4'(hold_idx)};
      for (int b = 0; b < RECORD_BYTES; b++) begin
         if (byte_idx == BI_W'(b + 1)) frame_byte = hold_rec[b*8 +: 8];
      end
   end

   assign more_work = i_enable && (|i_req);
   assign last_byte = (byte_idx == LAST_BYTE);

   always_comb begin
      state_nxt = state;
      o_ack     = '0;
      o_valid   = 1'b0;
      o_data    = '0;
      o_last    = 1'b0;
      xfer      = 1'b0;
      o_busy    = (state != IDLE);
      case (state)
         IDLE: begin
            if (more_work) state_nxt = GRANT;
         end
         GRANT: begin
            if (pick_found) begin
               // A gated cycle captures nothing, so it must not ack either.
               o_ack[pick_idx] = i_cg;
               state_nxt       = SEND;
            end else begin
               state_nxt = IDLE;
            end
         end
         SEND: begin
            o_valid = 1'b1;
            o_data  = frame_byte;
            // Short packet when the stream goes quiet after this frame.
            o_last  = (pkt_cnt == PKT_END) || (last_byte && !more_work);
            xfer    = i_ready;
            if (i_ready && last_byte) state_nxt = more_work ? GRANT : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else if (i_cg) begin
         state <= state_nxt;
      end
   end

   // NOTE: the holding register is reset along with the control state; it is a
   // single record wide, and a known value keeps o_data deterministic in tests.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rr_ptr   <= '0;
         byte_idx <= '0;
         pkt_cnt  <= '0;
         hold_rec <= '0;
         hold_idx <= '0;
      end else if (i_cg) begin
         if (state == GRANT && pick_found) begin
            hold_rec <= sel_rec;
            hold_idx <= pick_idx;
            rr_ptr   <= (pick_idx == IDX_W'(N_ENGINE - 1)) ? '0 : pick_idx + 1'b1;
            byte_idx <= '0;
         end
         if (xfer) begin
            byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
            pkt_cnt  <= o_last ? '0 : pkt_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bp_engine_result_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bp_engine_result_arbiter
// Engines are modelled as request/record holders that drop or reload their
// request after each ack. A frame-level scoreboard predicts the byte stream
// and packet boundaries; directed tests pin specific streams with literals.
// -----------------------------------------------------------------------------
module tb_bp_engine_result_arbiter;

   localparam int N    = 8;
   localparam int RB   = 4;
   localparam int MAXP = 16;
   localparam int RW   = RB * 8;

   typedef struct {
      logic [7:0] d;
      bit         fin;
   } exp_byte_t;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          cg    = 1'b1;
   logic          en    = 1'b1;
   logic          rdy   = 1'b1;
   logic [N-1:0]  req_bus = '0;
   logic [N*RW-1:0] rec_bus = '0;
   logic [N-1:0]  ack;
   logic [7:0]    data;
   logic          valid, last, busy;

   always #5 clk = ~clk;

   bp_engine_result_arbiter #(
      .N_ENGINE     (N),
      .RECORD_BYTES (RB),
      .MAX_PKT      (MAXP)
   ) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_cg     (cg),
      .i_enable (en),
      .i_req    (req_bus),
      .i_record (rec_bus),
      .o_ack    (ack),
      .o_data   (data),
      .o_valid  (valid),
      .i_ready  (rdy),
      .o_last   (last),
      .o_busy   (busy)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard / model (compare process) ----------------
   exp_byte_t  exp_q[$];
   int         mptr = 0;
   int         mpkt = 0;
   bit         prev_stall = 0;
   logic [7:0] prev_data = '0;
   logic [7:0] log_data[$];
   bit         log_last[$];
   int         log_eng[$];
   int         ack_cnt[N];

   always @(negedge clk) begin
      int        a, want;
      exp_byte_t eb;
      bit        exp_last;
      if (!rst_n) begin
         exp_q.delete();
         mptr       = 0;
         mpkt       = 0;
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            check("stall_valid_held", 32'(valid), 32'd1);
            check("stall_data_held", 32'(data), 32'(prev_data));
         end
         if (ack != '0) begin
            a = -1;
            for (int e = N - 1; e >= 0; e--) if (ack[e]) a = e;
            want = -1;
            for (int k = N - 1; k >= 0; k--) if (req_bus[(mptr + k) % N]) want = (mptr + k) % N;
            check("ack_onehot", 32'($countones(ack)), 32'd1);
            check("grant_rr", 32'(a), 32'(want));
            eb.d = {4'hA, 4'(a)}; eb.fin = 0;
            exp_q.push_back(eb);
            for (int b = 0; b < RB; b++) begin
               eb.d   = rec_bus[a*RW + b*8 +: 8];
               eb.fin = (b == RB - 1);
               exp_q.push_back(eb);
            end
            mptr = (a + 1) % N;
            log_eng.push_back(a);
            ack_cnt[a]++;
         end
         if (cg && valid && rdy) begin
            if (exp_q.size() == 0) begin
               check("stream_surplus", 32'(exp_q.size()), 32'd1);
            end else begin
               eb = exp_q.pop_front();
               exp_last = (mpkt == MAXP - 1) || (eb.fin && !(en && (req_bus != '0)));
               check("stream_byte", 32'(data), 32'(eb.d));
               check("stream_last", 32'(last), 32'(exp_last));
               mpkt = exp_last ? 0 : mpkt + 1;
               log_data.push_back(data);
               log_last.push_back(last);
            end
         end
         prev_stall = valid && !(cg && rdy);
         prev_data  = data;
      end
   end

   // ---------------- engine model and stimulus helpers ----------------
   int remaining[N];
   int seq[N];
   int ack_seen[N];

   function automatic logic [RW-1:0] mk_rec(input int e, input int n);
      return {8'(e * 17), 8'(n), 8'(8'hC0 + e), 8'(n * 3 + 1)};
   endfunction

   // Engines drop their request after the last acked record, else load the next.
   task automatic service();
      for (int e = 0; e < N; e++) begin
         while (ack_seen[e] < ack_cnt[e]) begin
            ack_seen[e]++;
            seq[e]++;
            remaining[e]--;
            if (remaining[e] > 0) rec_bus[e*RW +: RW] = mk_rec(e, seq[e]);
            else req_bus[e] = 1'b0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      service();
   endtask

   task automatic raise(input int e, input int cnt, input logic [RW-1:0] rec);
      remaining[e]        = cnt;
      rec_bus[e*RW +: RW] = rec;
      req_bus[e]          = 1'b1;
   endtask

   task automatic run_until_quiet(input int budget, output int busy_n);
      busy_n = 0;
      for (int c = 0; c < budget; c++) begin
         tick();
         @(negedge clk);
         if (busy) busy_n++;
         if (!busy && req_bus == '0) return;
      end
      check("quiet_timeout", 32'(busy), 32'd0);
   endtask

   task automatic wait_bytes(input int base, input int n, input int budget);
      for (int c = 0; c < budget; c++) begin
         if (log_data.size() - base >= n) return;
         tick();
      end
      check("byte_wait_timeout", 32'(log_data.size() - base), 32'(n));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int base, ebase, bn;
      logic [7:0] exp1[5];
      logic [7:0] exp4[5];

      // reset state
      tick();
      @(negedge clk);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_data", 32'(data), 32'd0);
      check("rst_last", 32'(last), 32'd0);
      tick();
      rst_n = 1'b1;

      // single request: latency and literal stream
      base = log_data.size();
      tick();
      raise(3, 1, 32'h4433_2211);
      @(negedge clk);
      check("t1_idle_busy", 32'(busy), 32'd0);
      tick();
      @(negedge clk);
      check("t1_ack", 32'(ack), 32'h08);
      tick();
      @(negedge clk);
      check("t1_hdr_valid", 32'(valid), 32'd1);
      check("t1_hdr_data", 32'(data), 32'hA3);
      run_until_quiet(40, bn);
      exp1 = '{8'hA3, 8'h11, 8'h22, 8'h33, 8'h44};
      check("t1_count", 32'(log_data.size() - base), 32'd5);
      for (int i = 0; i < 5; i++) begin
         check("t1_byte", 32'(log_data[base + i]), 32'(exp1[i]));
         check("t1_last", 32'(log_last[base + i]), 32'(i == 4));
      end

      // all engines requesting: round-robin order and packet boundaries
      do_reset();
      base  = log_data.size();
      ebase = log_eng.size();
      for (int e = 0; e < N; e++) raise(e, 1, mk_rec(e, 0));
      run_until_quiet(200, bn);
      check("t2_busy_cycles", 32'(bn), 32'd48);
      check("t2_count", 32'(log_data.size() - base), 32'd40);
      for (int e = 0; e < N; e++) check("t2_order", 32'(log_eng[ebase + e]), 32'(e));
      for (int i = 0; i < 40; i++) begin
         check("t2_last", 32'(log_last[base + i]), 32'(i == 15 || i == 31 || i == 39));
         if (i % 5 == 0) check("t2_header", 32'(log_data[base + i]), 32'({4'hA, 4'(i / 5)}));
      end

      // backpressure: ready toggling 1010
      base = log_data.size();
      tick();
      raise(5, 1, 32'hDDCC_BBAA);
      for (int c = 0; c < 14; c++) begin
         rdy = (c % 2 == 0);
         tick();
      end
      rdy = 1'b1;
      run_until_quiet(40, bn);
      exp4 = '{8'hA5, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      check("t3_count", 32'(log_data.size() - base), 32'd5);
      for (int i = 0; i < 5; i++) check("t3_byte", 32'(log_data[base + i]), 32'(exp4[i]));

      // enable dropped during byte 2 with another request pending
      base  = log_data.size();
      ebase = log_eng.size();
      tick();
      raise(1, 1, mk_rec(1, 7));
      raise(6, 1, mk_rec(6, 7));
      wait_bytes(base, 2, 30);
      en = 1'b0;
      for (int c = 0; c < 15; c++) tick();
      @(negedge clk);
      check("t4_idle", 32'(busy), 32'd0);
      check("t4_acks", 32'(log_eng.size() - ebase), 32'd1);
      check("t4_first", 32'(log_eng[ebase]), 32'd6);
      check("t4_count", 32'(log_data.size() - base), 32'd5);
      check("t4_last", 32'(log_last[base + 4]), 32'd1);
      tick();
      en = 1'b1;
      run_until_quiet(40, bn);
      check("t4_resume", 32'(log_eng[ebase + 1]), 32'd1);

      // pointer wrap: grant 6 moves pointer to 7; then 7 before 2
      tick();
      raise(6, 1, mk_rec(6, 9));
      run_until_quiet(40, bn);
      ebase = log_eng.size();
      raise(2, 1, mk_rec(2, 9));
      raise(7, 1, mk_rec(7, 9));
      run_until_quiet(60, bn);
      check("t5_first", 32'(log_eng[ebase]), 32'd7);
      check("t5_second", 32'(log_eng[ebase + 1]), 32'd2);

      // clock gate: no ack while gated in GRANT, outputs hold in SEND
      base = log_data.size();
      tick();
      raise(0, 1, 32'h0BAD_F00D);
      tick();
      cg = 1'b0;
      @(negedge clk);
      check("t6_gated_ack", 32'(ack), 32'd0);
      check("t6_gated_busy", 32'(busy), 32'd1);
      tick();
      @(negedge clk);
      check("t6_gated_ack2", 32'(ack), 32'd0);
      tick();
      cg = 1'b1;
      @(negedge clk);
      check("t6_ack", 32'(ack), 32'h01);
      tick();
      cg = 1'b0;
      @(negedge clk);
      check("t6_hold_data", 32'(data), 32'hA0);
      tick();
      @(negedge clk);
      check("t6_hold_data2", 32'(data), 32'hA0);
      tick();
      cg = 1'b1;
      run_until_quiet(40, bn);
      check("t6_count", 32'(log_data.size() - base), 32'd5);
      check("t6_byte1", 32'(log_data[base + 1]), 32'h0D);

      // reset mid-frame at byte 3, then fresh stream from pointer 0
      base = log_data.size();
      tick();
      raise(4, 1, mk_rec(4, 3));
      wait_bytes(base, 3, 30);
      rst_n = 1'b0;
      #1;
      check("t7_valid", 32'(valid), 32'd0);
      check("t7_busy", 32'(busy), 32'd0);
      check("t7_data", 32'(data), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      base  = log_data.size();
      ebase = log_eng.size();
      for (int e = 0; e < 4; e++) raise(e, 1, mk_rec(e, 5));
      run_until_quiet(100, bn);
      check("t7_count", 32'(log_data.size() - base), 32'd20);
      check("t7_hdr", 32'(log_data[base]), 32'hA0);
      for (int e = 0; e < 4; e++) check("t7_order", 32'(log_eng[ebase + e]), 32'(e));
      for (int i = 0; i < 20; i++) check("t7_last", 32'(log_last[base + i]), 32'(i == 15 || i == 19));

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
